data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/dmem_pkg.sv | 14 +
 rtl/data_mem_unit_if.sv | 22 ++
 rtl/dmem_array.sv | 21 ++
 rtl/data_mem_unit.sv | 168 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory unit.
package dmem_pkg;

    localparam int WORD_W  = 16;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/data_mem_unit_if.sv
// Memory-stage request/response bundle between the pipeline and data_mem_unit.
interface data_mem_unit_if;
    import dmem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [15:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              stall;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, stall, err
    );
endinterface

// File: rtl/dmem_array.sv
// 2^ADDR_W x 16 synchronous single-port RAM with registered read (read-before-write).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory with stall handshake and sticky error flag.
// Optional one-entry background write buffer: define DMEM_WRITE_BUFFER_EN.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_unit_if.slave bus
);
    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

    dmem_state_t       state;
    logic [2:0]        cnt;
    logic              op_store;
    logic              err_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] rdata_c;
    logic [WORD_W-1:0] arr_q;
    logic [WORD_W-1:0] arr_wdata;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] arr_addr;
    logic              is_load;
    logic              is_store;
    logic              start;
    logic              busy_last;
    logic              arr_we;
    logic              stall_c;

    assign word_addr = bus.addr[ADDR_W-1:0];
    assign is_store  = bus.mem_write;
    assign is_load   = bus.mem_read & ~bus.mem_write;
    // IDLE counts as the first stall cycle, so BUSY ends when the count reaches 1.
    assign busy_last = (state == BUSY) && (cnt <= 3'd1);

    if (ADDR_W < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.addr[15:ADDR_W];
    end

`ifdef DMEM_WRITE_BUFFER_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [WORD_W-1:0] buf_data;
    logic [2:0]        dcnt;
    logic              buf_hit;
    logic              drain_now;
    logic              buf_free;
    logic              capture;
    logic              load_hit;

    assign buf_hit   = buf_valid && (word_addr == buf_addr);
    assign drain_now = buf_valid && (dcnt == '0);
    // A store may refill the buffer on the same edge the old entry is written.
    assign buf_free  = !buf_valid || drain_now;
    assign capture   = (state == IDLE) && is_store && buf_free;
    assign load_hit  = (state == IDLE) && is_load && buf_hit;
    assign start     = (state == IDLE) && is_load && !buf_valid;
    assign stall_c   = ((state == IDLE) && is_store && !buf_free) ||
                       ((state == IDLE) && is_load && buf_valid && !buf_hit) ||
                       start || (state == BUSY);
    assign arr_we    = drain_now;
    assign arr_addr  = drain_now ? buf_addr : word_addr;
    assign arr_wdata = buf_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            dcnt      <= '0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_addr  <= word_addr;
            buf_data  <= bus.wdata;
            dcnt      <= LAT_M1;
        end else if (drain_now) begin
            buf_valid <= 1'b0;
        end else if (buf_valid) begin
            dcnt <= dcnt - 3'd1;
        end
    end
`else
    assign start     = (state == IDLE) && (is_load || is_store);
    assign stall_c   = start || (state == BUSY);
    assign arr_we    = (start && (LAT == 1) && is_store) || (busy_last && op_store);
    assign arr_addr  = word_addr;
    assign arr_wdata = bus.wdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_store <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.mem_read && bus.mem_write) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        op_store <= is_store;
                        if (LAT == 1) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            state <= BUSY;
                            cnt   <= LAT_M1;
                        end
                    end
`ifdef DMEM_WRITE_BUFFER_EN
                    if (load_hit) begin
                        rdata_q <= buf_data;
                    end
`endif
                end
                BUSY: begin
                    if (busy_last) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (!op_store) begin
                        rdata_q <= arr_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_c = rdata_q;
        if ((state == DONE) && !op_store) begin
            rdata_c = arr_q;
        end
`ifdef DMEM_WRITE_BUFFER_EN
        if (load_hit) begin
            rdata_c = buf_data;
        end
`endif
    end

    assign bus.rdata = rdata_c;
    assign bus.stall = stall_c & ~rst;
    assign bus.err   = err_q;

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_q)
    );
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit (LATENCY=2/ADDR_W=8 and LATENCY=1/ADDR_W=4 instances).
module tb_data_mem_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef DMEM_WRITE_BUFFER_EN
    localparam int ST2 = 0;
    localparam int ST1 = 0;
`else
    localparam int ST2 = 2;
    localparam int ST1 = 1;
`endif

    data_mem_unit_if dif ();
    data_mem_unit_if dif1 ();

    data_mem_unit #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    data_mem_unit #(.ADDR_W(4), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (dif1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        dif.mem_read   = 1'b0;
        dif.mem_write  = 1'b0;
        dif.addr       = '0;
        dif.wdata      = '0;
        dif1.mem_read  = 1'b0;
        dif1.mem_write = 1'b0;
        dif1.addr      = '0;
        dif1.wdata     = '0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic cur_stall(input bit sel);
        return sel ? dif1.stall : dif.stall;
    endfunction

    function automatic logic [15:0] cur_rdata(input bit sel);
        return sel ? dif1.rdata : dif.rdata;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the completion cycle.
    task automatic op(input bit sel, input string tag, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d,
                      input int exp_stall, input logic [15:0] exp_rd);
        int n = 0;
        if (sel) begin
            dif1.mem_read = rd; dif1.mem_write = wr; dif1.addr = a; dif1.wdata = d;
        end else begin
            dif.mem_read = rd; dif.mem_write = wr; dif.addr = a; dif.wdata = d;
        end
        @(negedge clk);
        while (cur_stall(sel) && n < 20) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("%s_stall", tag), n, exp_stall);
        check($sformatf("%s_rdata", tag), cur_rdata(sel), exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", dif.stall, 1'b0);
        check("rst_rdata", dif.rdata, 16'h0000);
        check("rst_err", dif.err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_stall", dif.stall, 1'b0);
        @(posedge clk);
        #1;

        op(0, "st5", 1'b0, 1'b1, 16'h0005, 16'h5A5A, ST2, 16'h0000);
        idle(3);
        op(0, "st10", 1'b0, 1'b1, 16'h0010, 16'h1234, ST2, 16'h0000);
        idle(3);

        // Asynchronous pulse between edges: array must survive.
        rst = 1'b1;
        #2;
        check("apulse_stall", dif.stall, 1'b0);
        check("apulse_err", dif.err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op(0, "ld5", 1'b1, 1'b0, 16'h0005, 16'h0000, 2, 16'h5A5A);
        op(0, "ld110_wrap", 1'b1, 1'b0, 16'h0110, 16'h0000, 2, 16'h1234);
        idle(1);
        check("hold_rdata", dif.rdata, 16'h1234);
        check("hold_stall", dif.stall, 1'b0);

        op(0, "both3", 1'b1, 1'b1, 16'h0003, 16'hBEEF, ST2, 16'h1234);
        check("both3_err", dif.err, 1'b1);
        idle(3);
        check("err_sticky", dif.err, 1'b1);
        op(0, "ld3", 1'b1, 1'b0, 16'h0003, 16'h0000, 2, 16'hBEEF);
        check("ld3_err", dif.err, 1'b1);

        // Reset while the load sits in BUSY.
        dif.mem_read = 1'b1;
        dif.addr     = 16'h0005;
        @(negedge clk);
        check("mid_idle_stall", dif.stall, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("mid_busy_stall", dif.stall, 1'b1);
        #1;
        rst = 1'b1;
        drive_idle();
        #1;
        check("mid_rst_stall", dif.stall, 1'b0);
        check("mid_rst_rdata", dif.rdata, 16'h0000);
        check("mid_rst_err", dif.err, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        op(0, "post_rst_ld3", 1'b1, 1'b0, 16'h0003, 16'h0000, 2, 16'hBEEF);
        check("post_rst_err", dif.err, 1'b0);
        idle(1);

`ifdef DMEM_WRITE_BUFFER_EN
        op(0, "wb_st20", 1'b0, 1'b1, 16'h0020, 16'hAAAA, 0, 16'hBEEF);
        op(0, "wb_ld20_hit", 1'b1, 1'b0, 16'h0020, 16'h0000, 0, 16'hAAAA);
        idle(3);
        op(0, "wb_st30", 1'b0, 1'b1, 16'h0030, 16'h1111, 0, 16'hAAAA);
        op(0, "wb_st31", 1'b0, 1'b1, 16'h0031, 16'h2222, 1, 16'hAAAA);
        idle(3);
        op(0, "wb_ld30", 1'b1, 1'b0, 16'h0030, 16'h0000, 2, 16'h1111);
        op(0, "wb_ld31", 1'b1, 1'b0, 16'h0031, 16'h0000, 2, 16'h2222);
        op(0, "wb_st40", 1'b0, 1'b1, 16'h0040, 16'h3333, 0, 16'h2222);
        op(0, "wb_ld30_miss", 1'b1, 1'b0, 16'h0030, 16'h0000, 4, 16'h1111);
        idle(3);
        op(0, "wb_ld40", 1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'h3333);
        idle(1);
`endif

        op(1, "l1_st7", 1'b0, 1'b1, 16'h0007, 16'hC0DE, ST1, 16'h0000);
        idle(2);
        op(1, "l1_ld17_wrap", 1'b1, 1'b0, 16'h0017, 16'h0000, 1, 16'hC0DE);
        op(1, "l1_ld7", 1'b1, 1'b0, 16'h0007, 16'h0000, 1, 16'hC0DE);
        idle(1);
        check("l1_idle_stall", dif1.stall, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
